// File: rtl/spi_fill_rect.sv
// spi_fill_rect: streams a solid-colour rectangle fill to an SPI panel
// controller. The rectangle is split into row bands of at most BAND rows.
// Each band sends three groups: column window (0x2A), page window (0x2B),
// and memory write (0x2C) followed by the RGB565 pixels. SPI is mode 0,
// MSB first, and o_cs is released between groups.
module spi_fill_rect #(
   parameter int WIDTH   = 240,
   parameter int HEIGHT  = 320,
   parameter int BAND    = 8,
   parameter int CLK_DIV = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [8:0]  i_x0,
   input  logic [8:0]  i_x1,
   input  logic [8:0]  i_y0,
   input  logic [8:0]  i_y1,
   input  logic [15:0] i_color,
   output logic        o_sclk,
   output logic        o_mosi,
   output logic        o_dc,
   output logic        o_cs,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GW = $clog2(2 * CLK_DIV + 1);
   localparam int PW = 21;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(2 * CLK_DIV);
   localparam logic [10:0]   W_L      = 11'(WIDTH);
   localparam logic [10:0]   H_L      = 11'(HEIGHT);
   localparam logic [10:0]   BAND_M1  = 11'(BAND - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_CMD, S_DATA, S_GAP, S_NEXT_BAND, S_FINISH
   } state_t;

   state_t        state_q;
   logic [8:0]    x0_q, x1_q, y0_q, y1_q;
   logic [15:0]   color_q;
   logic [10:0]   yb_q;
   logic [1:0]    grp_q;    // 0: column window, 1: page window, 2: pixels
   logic [2:0]    bidx_q;   // next window data byte index
   logic [2:0]    bit_q;
   logic [DW-1:0] div_q;
   logic [GW-1:0] gap_q;
   logic [6:0]    sh_q;     // bits still to send after the one on o_mosi
   logic [PW-1:0] pix_q;    // pixels left in the band, current one included
   logic          lo_q;     // current pixel byte is the low byte
   logic          sclk_q, mosi_q, dc_q, cs_q, busy_q, done_q, err_q;

   logic [10:0]   y1_ext, ye_sum, ye, nrows;
   logic [9:0]    ncols;
   logic [PW-1:0] npix;
   logic          reject;
   logic [15:0]   pa, pb;
   logic [1:0]    pidx;
   logic [7:0]    nxt_byte;
   logic          nxt_last;

   // Band geometry and request validation from the latched coordinates
   always_comb begin
      y1_ext = {2'b00, y1_q};
      ye_sum = yb_q + BAND_M1;
      ye     = (ye_sum > y1_ext) ? y1_ext : ye_sum;
      ncols  = {1'b0, x1_q} - {1'b0, x0_q} + 10'd1;
      nrows  = ye - yb_q + 11'd1;
      npix   = PW'(ncols) * PW'(nrows);
      reject = (x0_q > x1_q) || (y0_q > y1_q) ||
               ({2'b00, x1_q} >= W_L) || (y1_ext >= H_L);
   end

   // Byte that follows the one in flight, and whether the group ends instead
   always_comb begin
      pa       = (grp_q == 2'd0) ? {7'd0, x0_q} : {5'd0, yb_q};
      pb       = (grp_q == 2'd0) ? {7'd0, x1_q} : {5'd0, ye};
      pidx     = (state_q == S_CMD) ? 2'd0 : bidx_q[1:0];
      nxt_byte = 8'h00;
      nxt_last = 1'b0;
      if (grp_q == 2'd2) begin
         nxt_byte = (state_q == S_CMD || lo_q) ? color_q[15:8] : color_q[7:0];
         nxt_last = (state_q == S_DATA) && lo_q && (pix_q == PW'(1));
      end else begin
         case (pidx)
            2'd0:    nxt_byte = pa[15:8];
            2'd1:    nxt_byte = pa[7:0];
            2'd2:    nxt_byte = pb[15:8];
            default: nxt_byte = pb[7:0];
         endcase
         nxt_last = (state_q == S_DATA) && (bidx_q == 3'd4);
      end
   end

   // Request sequencing, SPI bit engine and registered pin outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         x0_q    <= '0;
         x1_q    <= '0;
         y0_q    <= '0;
         y1_q    <= '0;
         color_q <= '0;
         yb_q    <= '0;
         grp_q   <= '0;
         bidx_q  <= '0;
         bit_q   <= '0;
         div_q   <= '0;
         gap_q   <= '0;
         sh_q    <= '0;
         pix_q   <= '0;
         lo_q    <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         dc_q    <= 1'b0;
         cs_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  x0_q    <= i_x0;
                  x1_q    <= i_x1;
                  y0_q    <= i_y0;
                  y1_q    <= i_y1;
                  color_q <= i_color;
                  busy_q  <= 1'b1;
                  state_q <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (reject) begin
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_FINISH;
               end else begin
                  yb_q    <= {2'b00, y0_q};
                  grp_q   <= 2'd0;
                  sh_q    <= 7'h2A;   // 0x2A, MSB (0) goes straight to o_mosi
                  mosi_q  <= 1'b0;
                  dc_q    <= 1'b0;
                  cs_q    <= 1'b0;
                  bit_q   <= '0;
                  div_q   <= '0;
                  sclk_q  <= 1'b0;
                  state_q <= S_CMD;
               end
            end
            S_CMD, S_DATA: begin
               if (div_q != DIV_LAST) begin
                  div_q <= div_q + 1'b1;
               end else begin
                  div_q <= '0;
                  if (!sclk_q) begin
                     sclk_q <= 1'b1;
                  end else begin
                     sclk_q <= 1'b0;
                     if (bit_q != 3'd7) begin
                        bit_q  <= bit_q + 3'd1;
                        sh_q   <= {sh_q[5:0], 1'b0};
                        mosi_q <= sh_q[6];
                     end else if (nxt_last) begin
                        // cs stays low this cycle so it rises after the last fall
                        gap_q   <= '0;
                        state_q <= S_GAP;
                     end else begin
                        bit_q   <= '0;
                        sh_q    <= nxt_byte[6:0];
                        mosi_q  <= nxt_byte[7];
                        dc_q    <= 1'b1;
                        state_q <= S_DATA;
                        if (state_q == S_CMD) begin
                           bidx_q <= 3'd1;
                           pix_q  <= npix;
                           lo_q   <= 1'b0;
                        end else begin
                           bidx_q <= bidx_q + 3'd1;
                           if (lo_q) pix_q <= pix_q - PW'(1);
                           lo_q   <= ~lo_q;
                        end
                     end
                  end
               end
            end
            S_GAP: begin
               cs_q <= 1'b1;
               if (gap_q != GAP_LAST) begin
                  gap_q <= gap_q + 1'b1;
               end else if (grp_q == 2'd2) begin
                  state_q <= S_NEXT_BAND;
               end else begin
                  grp_q   <= grp_q + 2'd1;
                  sh_q    <= 7'h2B + {5'd0, grp_q};   // 0x2B or 0x2C
                  mosi_q  <= 1'b0;
                  dc_q    <= 1'b0;
                  cs_q    <= 1'b0;
                  bit_q   <= '0;
                  div_q   <= '0;
                  state_q <= S_CMD;
               end
            end
            S_NEXT_BAND: begin
               if (ye == y1_ext) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_FINISH;
               end else begin
                  yb_q    <= ye + 11'd1;
                  grp_q   <= 2'd0;
                  sh_q    <= 7'h2A;
                  mosi_q  <= 1'b0;
                  dc_q    <= 1'b0;
                  cs_q    <= 1'b0;
                  bit_q   <= '0;
                  div_q   <= '0;
                  state_q <= S_CMD;
               end
            end
            S_FINISH: state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   assign o_sclk = sclk_q;
   assign o_mosi = mosi_q;
   assign o_dc   = dc_q;
   assign o_cs   = cs_q;
   assign o_busy = busy_q;
   assign o_done = done_q;
   assign o_err  = err_q;
endmodule

// File: doc/spi_fill_rect.md
SPI_FILL_RECT -- requirements
Module: spi_fill_rect

Interface
REQ-001 Parameter WIDTH, default 240, panel column count.
REQ-002 Parameter HEIGHT, default 320, panel row count.
REQ-003 Parameter BAND, default 8, max rows per page window (1..HEIGHT).
REQ-004 Parameter CLK_DIV, default 2, i_clk cycles per SCLK half-period (>=1).
REQ-005 i_clk  in  1  system clock.
REQ-006 i_rst  in  1  reset, asynchronous, active-high.
REQ-007 i_start  in  1  request pulse; sampled only in IDLE.
REQ-008 i_x0, i_x1  in  9 each  inclusive column bounds.
REQ-009 i_y0, i_y1  in  9 each  inclusive row bounds.
REQ-010 i_color  in  16  RGB565 fill colour.
REQ-011 o_sclk  out  1  SPI clock, mode 0, idle low.
REQ-012 o_mosi  out  1  SPI data, MSB first.
REQ-013 o_dc  out  1  0 = command byte, 1 = data byte.
REQ-014 o_cs  out  1  chip select, active low.
REQ-015 o_busy  out  1  high from the cycle after start acceptance until o_done.
REQ-016 o_done  out  1  one-cycle completion pulse.
REQ-017 o_err  out  1  one-cycle pulse coincident with o_done when the request was rejected.

Function
REQ-018 States: IDLE, CHECK, CMD, DATA, GAP, NEXT_BAND, FINISH.
REQ-019 IDLE + i_start: latch x0,x1,y0,y1,color; go to CHECK; later changes on the inputs are ignored.
REQ-020 CHECK: reject if x0>x1, y0>y1, x1>=WIDTH or y1>=HEIGHT -> FINISH with o_err, no SPI activity; else set band row yb=y0 -> CMD.
REQ-021 Band end ye = min(yb+BAND-1, y1); computation width >= 10 bits, no wrap.
REQ-022 Per band, three groups in order: 0x2A + {x0[15:8],x0[7:0],x1[15:8],x1[7:0]}; 0x2B + {yb hi,yb lo,ye hi,ye lo}; 0x2C + (x1-x0+1)*(ye-yb+1) pixels.
REQ-023 Coordinates are zero-extended to 16 bits before the byte split.
REQ-024 Each pixel is sent as color[15:8] then color[7:0]; the pixel counter is at least 17 bits wide (76800 max).
REQ-025 Per group: o_cs low before the first SCLK rising edge; o_dc=0 for the command byte and 1 for its data bytes; o_dc is stable for the whole byte.
REQ-026 Bytes within a group are back-to-back with no SCLK gap; o_cs rises after the last falling edge of the group.
REQ-027 GAP: o_cs high for >= 2*CLK_DIV i_clk cycles between groups.
REQ-028 Byte timing: 8 SCLK periods of 2*CLK_DIV cycles each; o_mosi changes on the falling edge or at the byte start; the receiver samples on the rising edge.
REQ-029 NEXT_BAND: if ye==y1 -> FINISH, else yb=ye+1 -> CMD.
REQ-030 FINISH: o_done=1 (and o_err per REQ-020) for one cycle, o_busy=0 that same cycle -> IDLE.
REQ-031 i_start while busy is ignored; i_start in the cycle o_done pulses is also ignored.
REQ-032 Accepted start to first o_cs fall: <= 3 cycles.
REQ-033 A single-pixel rectangle (x0==x1, y0==y1) is legal: one band, 2 pixel bytes.

Reset
REQ-034 While i_rst is high: state IDLE, o_sclk=0, o_mosi=0, o_dc=0, o_cs=1, o_busy=0, o_done=0, o_err=0, counters zero.
REQ-035 Reset mid-transfer aborts immediately: o_cs high and no o_done pulse; the first start after release behaves like a fresh request.

Verification
REQ-036 Full clear (0,239,0,319), color 0x0000, BAND=8 -> 40 bands; each band sends 2A 00 00 00 EF, 2B yb/ye, 2C + 3840 zero bytes; last band page is 0x0138..0x013F; one o_done.
REQ-037 Rect (10,12,300,302), color 0xF800, BAND=8 -> 1 band; page 01 2C 01 2E; 9 pixels = 18 bytes alternating F8,00; o_err=0.
REQ-038 y-range 5..20 with BAND=8 -> bands 5-12, 13-20; then y-range 5..13 -> bands 5-12, 13-13 (short last band).
REQ-039 x0=5, x1=4 -> o_done+o_err within 3 cycles, o_cs never low; x1=240 -> same.
REQ-040 Assert i_rst mid-pixel stream -> o_cs=1, o_busy=0 the same cycle; a new start afterwards yields the correct complete sequence.
REQ-041 Pulse i_start while busy, with i_color changed -> ignored; bytes keep the latched colour; exactly one o_done.
